// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the I-cache refill controller and its neighbours:
// the stage-2 hit logic, the tag/data/LRU arrays and the L2 read port.
interface icache_refill_ctrl_if #(
  parameter int WAYS   = 4,
  parameter int IDX_W  = 6,
  parameter int LINE_W = 512
);
  logic               miss_vld;
  logic [31:0]        miss_pc;
  logic               flush;
  logic               cacop_vld;
  logic [1:0]         cacop_op;
  logic [31:0]        cacop_addr;
  logic               if_hold;
  logic               refill_done;
  logic               cacop_done;
  logic [IDX_W-1:0]   arr_rd_idx;
  logic [WAYS-1:0]    arr_vld_rd;
  logic [20*WAYS-1:0] arr_tag_rd;
  logic [2*WAYS-1:0]  arr_lru_rd;
  logic               arr_wr_en;
  logic               arr_data_we;
  logic [WAYS-1:0]    arr_wr_way;
  logic [IDX_W-1:0]   arr_wr_idx;
  logic               arr_wr_vld;
  logic [19:0]        arr_wr_tag;
  logic [LINE_W-1:0]  arr_wr_data;
  logic               arr_lru_we;
  logic [2*WAYS-1:0]  arr_lru_wdata;
  logic               l2_req;
  logic               l2_req_op;
  logic [31:0]        l2_req_addr;
  logic               l2_ack;
  logic [LINE_W-1:0]  l2_rd_data;

  modport master (
    input  miss_vld, miss_pc, flush, cacop_vld, cacop_op, cacop_addr,
    input  arr_vld_rd, arr_tag_rd, arr_lru_rd, l2_ack, l2_rd_data,
    output if_hold, refill_done, cacop_done, arr_rd_idx,
    output arr_wr_en, arr_data_we, arr_wr_way, arr_wr_idx, arr_wr_vld,
    output arr_wr_tag, arr_wr_data, arr_lru_we, arr_lru_wdata,
    output l2_req, l2_req_op, l2_req_addr
  );

  modport slave (
    output miss_vld, miss_pc, flush, cacop_vld, cacop_op, cacop_addr,
    output arr_vld_rd, arr_tag_rd, arr_lru_rd, l2_ack, l2_rd_data,
    input  if_hold, refill_done, cacop_done, arr_rd_idx,
    input  arr_wr_en, arr_data_we, arr_wr_way, arr_wr_idx, arr_wr_vld,
    input  arr_wr_tag, arr_wr_data, arr_lru_we, arr_lru_wdata,
    input  l2_req, l2_req_op, l2_req_addr
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache refill and CACOP sequencer: victim selection, L2 line fetch,
// array fill with LRU aging, and tag/valid maintenance operations.
// Only one operation is in flight; fetch is held while the FSM is busy.
module icache_refill_ctrl #(
  parameter int WAYS   = 4,
  parameter int IDX_W  = 6,
  parameter int LINE_W = 512
) (
  input logic clk,
  input logic rst_n,
  icache_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, MISS_RD, REQ, FILL, CC_RD, CC_WR} state_t;

  state_t            state, state_nxt;
  logic [19:0]       tag_q;        // miss tag, or CACOP PPN
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        cway_q;       // CACOP way field for index ops
  logic [1:0]        op_q;
  logic              drop_q;
  logic [WAYS-1:0]   way_q;        // one-hot victim (miss) or target (CACOP)
  logic [1:0]        old_age_q;
  logic [LINE_W-1:0] line_q;

  logic [WAYS-1:0]   victim;
  logic [1:0]        victim_age;
  logic              victim_found;
  logic [WAYS-1:0]   target;
  logic              target_hit;
  logic [2*WAYS-1:0] lru_new;

  // Victim: lowest invalid way, else the oldest (age 3) way, else way 0
  always_comb begin
    victim       = '0;
    victim_age   = bus.arr_lru_rd[1:0];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !bus.arr_vld_rd[w]) begin
        victim[w]    = 1'b1;
        victim_age   = 2'd3;
        victim_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && bus.arr_lru_rd[2*w +: 2] == 2'd3) begin
        victim[w]    = 1'b1;
        victim_age   = 2'd3;
        victim_found = 1'b1;
      end
    end
    if (!victim_found) victim[0] = 1'b1;
  end

  // CACOP target way: explicit way for index ops, tag match for hit_inval
  always_comb begin
    target     = '0;
    target_hit = 1'b0;
    case (op_q)
      2'd0, 2'd1: target[cway_q] = 1'b1;
      2'd2: begin
        for (int w = 0; w < WAYS; w++) begin
          if (!target_hit && bus.arr_vld_rd[w] &&
              bus.arr_tag_rd[20*w +: 20] == tag_q) begin
            target[w]  = 1'b1;
            target_hit = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // New LRU ages: victim becomes youngest, ways younger than it age by one
  always_comb begin
    lru_new = bus.arr_lru_rd;
    for (int w = 0; w < WAYS; w++) begin
      if (way_q[w])
        lru_new[2*w +: 2] = 2'd0;
      else if (bus.arr_lru_rd[2*w +: 2] < old_age_q)
        lru_new[2*w +: 2] = bus.arr_lru_rd[2*w +: 2] + 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latched request, victim/target, L2 line and flush-drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      idx_q     <= '0;
      cway_q    <= '0;
      op_q      <= '0;
      drop_q    <= 1'b0;
      way_q     <= '0;
      old_age_q <= '0;
      line_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cacop_vld) begin
            tag_q  <= bus.cacop_addr[31:12];
            idx_q  <= bus.cacop_addr[6 +: IDX_W];
            cway_q <= bus.cacop_addr[1:0];
            op_q   <= bus.cacop_op;
          end else if (bus.miss_vld) begin
            tag_q <= bus.miss_pc[31:12];
            idx_q <= bus.miss_pc[6 +: IDX_W];
          end
        end
        MISS_RD: begin
          way_q     <= victim;
          old_age_q <= victim_age;
        end
        REQ:     if (bus.l2_ack) line_q <= bus.l2_rd_data;
        CC_RD:   way_q <= target;
        default: ;
      endcase
      if (bus.flush && (state == MISS_RD || state == REQ || state == FILL))
        drop_q <= 1'b1;
      if (state_nxt == IDLE)
        drop_q <= 1'b0;
    end
  end

  // Next-state logic and all array / L2 / fetch-side outputs
  always_comb begin
    state_nxt         = state;
    bus.if_hold       = (state != IDLE) | bus.miss_vld | bus.cacop_vld;
    bus.refill_done   = 1'b0;
    bus.cacop_done    = 1'b0;
    bus.arr_rd_idx    = idx_q;
    bus.arr_wr_en     = 1'b0;
    bus.arr_data_we   = 1'b0;
    bus.arr_wr_way    = '0;
    bus.arr_wr_idx    = '0;
    bus.arr_wr_vld    = 1'b0;
    bus.arr_wr_tag    = '0;
    bus.arr_lru_we    = 1'b0;
    bus.arr_lru_wdata = '0;
    bus.l2_req        = 1'b0;
    bus.l2_req_addr   = '0;
    case (state)
      IDLE: begin
        bus.arr_rd_idx = bus.cacop_vld ? bus.cacop_addr[6 +: IDX_W]
                                       : bus.miss_pc[6 +: IDX_W];
        if (bus.cacop_vld)     state_nxt = CC_RD;
        else if (bus.miss_vld) state_nxt = MISS_RD;
      end
      MISS_RD: state_nxt = REQ;
      REQ: begin
        bus.l2_req      = 1'b1;
        bus.l2_req_addr = {tag_q, idx_q, 6'b0};
        if (bus.l2_ack) state_nxt = FILL;
      end
      FILL: begin
        bus.arr_wr_en     = 1'b1;
        bus.arr_data_we   = 1'b1;
        bus.arr_lru_we    = 1'b1;
        bus.arr_wr_way    = way_q;
        bus.arr_wr_idx    = idx_q;
        bus.arr_wr_vld    = 1'b1;
        bus.arr_wr_tag    = tag_q;
        bus.arr_lru_wdata = lru_new;
        bus.refill_done   = ~drop_q & ~bus.flush;
        state_nxt         = IDLE;
      end
      CC_RD: state_nxt = CC_WR;
      CC_WR: begin
        bus.arr_wr_en  = |way_q;
        bus.arr_wr_way = way_q;
        bus.arr_wr_idx = idx_q;
        bus.arr_wr_vld = 1'b0;
        bus.arr_wr_tag = (op_q == 2'd2) ? tag_q : 20'd0;
        bus.cacop_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.l2_req_op   = 1'b0;
  assign bus.arr_wr_data = line_q;

endmodule
